// File: rtl/kbd_edit_ctrl.sv
// rtl/kbd_edit_ctrl.sv - keyboard-driven RTC field editor with commit handshake
module kbd_edit_ctrl #(
    parameter logic [7:0] KEY_F   = 8'h2B,
    parameter logic [7:0] KEY_H   = 8'h33,
    parameter logic [7:0] KEY_T   = 8'h2C,
    parameter logic [7:0] KEY_UP  = 8'h75,
    parameter logic [7:0] KEY_DN  = 8'h72,
    parameter logic [7:0] KEY_LT  = 8'h6B,
    parameter logic [7:0] KEY_RT  = 8'h74,
    parameter logic [7:0] KEY_ESC = 8'h76
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_code,
    input  logic       key_new,
    input  logic [7:0] snap_a,
    input  logic [7:0] snap_b,
    input  logic [7:0] snap_c,
    input  logic       wr_ack,
    output logic       rx_en,
    output logic [1:0] mode,
    output logic [1:0] cursor,
    output logic [7:0] f_a,
    output logic [7:0] f_b,
    output logic [7:0] f_c,
    output logic       wr_req,
    output logic       edit_active
);

    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_WRITE} state_t;

    state_t     state_q;
    logic       key_q;
    logic [1:0] mode_q, cursor_q;
    logic [7:0] fa_q, fb_q, fc_q;
    logic       wr_req_q, edit_q, rx_en_q;

    logic       key_evt;
    logic [1:0] letter_mode;
    logic [7:0] sel_v, lim_lo, lim_hi, step_v;

    // Out-of-range or non-BCD values snap to the minimum on the first step.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi, input logic up);
        logic [7:0] r;
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v < lo || v > hi)
            r = lo;
        else if (up)
            r = (v == hi) ? lo : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
        else
            r = (v == lo) ? hi : (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    assign key_evt = key_new & ~key_q;

    always_comb begin
        letter_mode = 2'd0;
        if (key_code == KEY_H)      letter_mode = 2'd1;
        else if (key_code == KEY_F) letter_mode = 2'd2;
        else if (key_code == KEY_T) letter_mode = 2'd3;

        case (cursor_q)
            2'd0:    sel_v = fa_q;
            2'd1:    sel_v = fb_q;
            default: sel_v = fc_q;
        endcase

        if (mode_q == 2'd2) begin
            case (cursor_q)
                2'd0:    begin lim_lo = 8'h01; lim_hi = 8'h31; end
                2'd1:    begin lim_lo = 8'h01; lim_hi = 8'h12; end
                default: begin lim_lo = 8'h00; lim_hi = 8'h99; end
            endcase
        end else begin
            lim_lo = 8'h00;
            lim_hi = (cursor_q == 2'd0) ? 8'h23 : 8'h59;
        end

        step_v = bcd_step(sel_v, lim_lo, lim_hi, key_code == KEY_UP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            key_q    <= 1'b0;
            mode_q   <= 2'd0;
            cursor_q <= 2'd0;
            fa_q     <= 8'h00;
            fb_q     <= 8'h00;
            fc_q     <= 8'h00;
            wr_req_q <= 1'b0;
            edit_q   <= 1'b0;
            rx_en_q  <= 1'b1;
        end else begin
            key_q <= key_new;
            case (state_q)
                S_IDLE: begin
                    if (key_evt && letter_mode != 2'd0) begin
                        mode_q   <= letter_mode;
                        cursor_q <= 2'd0;
                        fa_q     <= (letter_mode == 2'd3) ? 8'h00 : snap_a;
                        fb_q     <= (letter_mode == 2'd3) ? 8'h00 : snap_b;
                        fc_q     <= (letter_mode == 2'd3) ? 8'h00 : snap_c;
                        state_q  <= S_EDIT;
                        edit_q   <= 1'b1;
                    end
                end
                S_EDIT: begin
                    if (key_evt) begin
                        if (key_code == KEY_RT) begin
                            cursor_q <= (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
                        end else if (key_code == KEY_LT) begin
                            cursor_q <= (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
                        end else if (key_code == KEY_UP || key_code == KEY_DN) begin
                            case (cursor_q)
                                2'd0:    fa_q <= step_v;
                                2'd1:    fb_q <= step_v;
                                default: fc_q <= step_v;
                            endcase
                        end else if (key_code == KEY_ESC) begin
                            state_q <= S_IDLE;
                            mode_q  <= 2'd0;
                            edit_q  <= 1'b0;
                        end else if (letter_mode != 2'd0 && letter_mode == mode_q) begin
                            state_q  <= S_WRITE;
                            wr_req_q <= 1'b1;
                            rx_en_q  <= 1'b0;
                            edit_q   <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_ack) begin
                        state_q  <= S_IDLE;
                        wr_req_q <= 1'b0;
                        rx_en_q  <= 1'b1;
                        mode_q   <= 2'd0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_en       = rx_en_q;
    assign mode        = mode_q;
    assign cursor      = cursor_q;
    assign f_a         = fa_q;
    assign f_b         = fb_q;
    assign f_c         = fc_q;
    assign wr_req      = wr_req_q;
    assign edit_active = edit_q;

endmodule

// File: tb/tb_kbd_edit_ctrl.sv
// tb/tb_kbd_edit_ctrl.sv - bench for kbd_edit_ctrl: decimal-value model plus directed literals
module tb_kbd_edit_ctrl;

    localparam logic [7:0] K_F = 8'h2B, K_H = 8'h33, K_T = 8'h2C, K_UP = 8'h75;
    localparam logic [7:0] K_DN = 8'h72, K_LT = 8'h6B, K_RT = 8'h74, K_ESC = 8'h76;

    logic       clk = 1'b0, reset = 1'b1;
    logic [7:0] key_code = 8'h00;
    logic       key_new = 1'b0;
    logic [7:0] snap_a = 8'h23, snap_b = 8'h59, snap_c = 8'h58;
    logic       wr_ack = 1'b0;
    logic       rx_en, wr_req, edit_active;
    logic [1:0] mode, cursor;
    logic [7:0] f_a, f_b, f_c;

    int vectors = 0, miscompares = 0;

    kbd_edit_ctrl dut (
        .clk(clk), .reset(reset), .key_code(key_code), .key_new(key_new),
        .snap_a(snap_a), .snap_b(snap_b), .snap_c(snap_c), .wr_ack(wr_ack),
        .rx_en(rx_en), .mode(mode), .cursor(cursor), .f_a(f_a), .f_b(f_b), .f_c(f_c),
        .wr_req(wr_req), .edit_active(edit_active)
    );

    always #5 clk = ~clk;

    // Model holds fields as plain decimal integers; raw bytes only for unvalidated snapshots.
    int         m_state, m_mode, m_cur;
    int         m_val[3];
    logic [7:0] m_raw[3];
    bit         m_ok[3];
    bit         m_prev;

    function automatic int letter(input logic [7:0] k);
        return (k == K_H) ? 1 : (k == K_F) ? 2 : (k == K_T) ? 3 : 0;
    endfunction

    function automatic int lim_lo(input int md, input int i);
        return (md == 2 && i < 2) ? 1 : 0;
    endfunction

    function automatic int lim_hi(input int md, input int i);
        if (md == 2) return (i == 0) ? 31 : (i == 1) ? 12 : 99;
        return (i == 0) ? 23 : 59;
    endfunction

    function automatic logic [7:0] f_exp(input int i);
        return m_ok[i] ? 8'((m_val[i] / 10) * 16 + m_val[i] % 10) : m_raw[i];
    endfunction

    task automatic m_load(input int i, input logic [7:0] s);
        m_raw[i] = s;
        m_ok[i]  = (s[7:4] <= 4'd9) && (s[3:0] <= 4'd9);
        m_val[i] = int'(s[7:4]) * 10 + int'(s[3:0]);
    endtask

    task automatic m_step(input int i, input bit up);
        int lo, hi;
        lo = lim_lo(m_mode, i);
        hi = lim_hi(m_mode, i);
        if (!m_ok[i] || m_val[i] < lo || m_val[i] > hi) begin
            m_val[i] = lo;
            m_ok[i]  = 1'b1;
        end else if (up) m_val[i] = (m_val[i] == hi) ? lo : m_val[i] + 1;
        else             m_val[i] = (m_val[i] == lo) ? hi : m_val[i] - 1;
    endtask

    always @(posedge clk or posedge reset) begin
        bit ev;
        int lm;
        if (reset) begin
            m_state = 0; m_mode = 0; m_cur = 0; m_prev = 1'b0;
            for (int i = 0; i < 3; i++) begin m_val[i] = 0; m_ok[i] = 1'b1; m_raw[i] = 8'h00; end
        end else begin
            ev = key_new && !m_prev;
            m_prev = key_new;
            lm = letter(key_code);
            if (m_state == 0) begin
                if (ev && lm != 0) begin
                    m_mode = lm; m_cur = 0; m_state = 1;
                    m_load(0, lm == 3 ? 8'h00 : snap_a);
                    m_load(1, lm == 3 ? 8'h00 : snap_b);
                    m_load(2, lm == 3 ? 8'h00 : snap_c);
                end
            end else if (m_state == 1) begin
                if (ev) begin
                    if (key_code == K_RT)       m_cur = (m_cur + 1) % 3;
                    else if (key_code == K_LT)  m_cur = (m_cur + 2) % 3;
                    else if (key_code == K_UP)  m_step(m_cur, 1'b1);
                    else if (key_code == K_DN)  m_step(m_cur, 1'b0);
                    else if (key_code == K_ESC) begin m_state = 0; m_mode = 0; end
                    else if (lm != 0 && lm == m_mode) m_state = 2;
                end
            end else if (wr_ack) begin
                m_state = 0; m_mode = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {1'b0, rx_en, mode, cursor, f_a, f_b, f_c, wr_req, edit_active};
    endfunction

    always @(negedge clk) begin
        chk("model", dut_vec(),
            {1'b0, m_state != 2, 2'(m_mode), 2'(m_cur), f_exp(0), f_exp(1), f_exp(2),
             m_state == 2, m_state == 1});
    end

    task automatic press(input logic [7:0] k);
        @(posedge clk); #1 key_code = k; key_new = 1'b1;
        @(posedge clk); #1 key_new = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(3);
        chk("reset_state", dut_vec(), 32'h4000_0000);
        reset = 1'b0;
        idle(2);

        press(K_H);
        chk("h_mode", {30'd0, mode}, 32'd1);
        chk("h_fields", {8'd0, f_a, f_b, f_c}, 32'h0023_5958);
        chk("h_edit", {30'd0, edit_active, cursor == 2'd0}, 32'd3);
        press(K_UP);  chk("time_up_wrap", {24'd0, f_a}, 32'h00);
        press(K_DN);  chk("time_dn_wrap", {24'd0, f_a}, 32'h23);
        press(K_RT);  chk("cursor_1", {30'd0, cursor}, 32'd1);
        press(K_RT);  chk("cursor_2", {30'd0, cursor}, 32'd2);
        press(K_RT);  chk("cursor_0", {30'd0, cursor}, 32'd0);
        press(K_F);   chk("other_letter", {30'd0, mode}, 32'd1);
        press(8'h11);
        press(K_RT);
        press(K_RT);
        @(posedge clk); #1 key_code = K_UP; key_new = 1'b1;
        idle(10);
        key_new = 1'b0;
        idle(1);
        chk("held_key_once", {24'd0, f_c}, 32'h59);

        press(K_H);
        chk("commit_req", {30'd0, wr_req, rx_en}, 32'd2);
        press(K_UP);
        idle(3);
        chk("write_hold", {23'd0, wr_req, f_c}, 32'h159);
        @(posedge clk); #1 key_code = K_UP; key_new = 1'b1; wr_ack = 1'b1;
        @(posedge clk); #1 wr_ack = 1'b0; key_new = 1'b0;
        chk("ack_done", {27'd0, wr_req, mode, rx_en, edit_active}, 32'h2);
        chk("ack_fields", {8'd0, f_a, f_b, f_c}, 32'h0023_5959);

        snap_a = 8'h01; snap_b = 8'h12; snap_c = 8'h09;
        press(K_F);   chk("date_mode", {30'd0, mode}, 32'd2);
        press(K_DN);  chk("date_a_wrap", {24'd0, f_a}, 32'h31);
        press(K_RT); press(K_UP);
        chk("date_b_wrap", {24'd0, f_b}, 32'h01);
        press(K_RT); press(K_UP);
        chk("date_c_carry", {24'd0, f_c}, 32'h10);
        press(K_ESC);
        chk("esc_state", {29'd0, mode, wr_req}, 32'd0);
        chk("esc_fields", {8'd0, f_a, f_b, f_c}, 32'h0031_0110);

        press(K_T);   chk("timer_zero", {8'd0, f_a, f_b, f_c}, 32'h0000_0000);
        press(K_DN);  chk("timer_a", {24'd0, f_a}, 32'h23);
        press(K_LT);  chk("cursor_lt_wrap", {30'd0, cursor}, 32'd2);
        press(K_DN);  chk("timer_c", {24'd0, f_c}, 32'h59);
        press(K_ESC);

        snap_a = 8'h3A; snap_b = 8'h75; snap_c = 8'h00;
        press(K_H);   chk("raw_load", {16'd0, f_a, f_b}, 32'h3A75);
        press(K_UP);  chk("sat_up", {24'd0, f_a}, 32'h00);
        press(K_RT); press(K_DN);
        chk("sat_dn", {24'd0, f_b}, 32'h00);

        press(K_H);
        chk("req_before_reset", {31'd0, wr_req}, 32'd1);
        #2 reset = 1'b1;
        #1 chk("async_reset", dut_vec(), 32'h4000_0000);
        idle(2);
        reset = 1'b0;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
